// File: rtl/step_scheduler_pkg.sv
// Shared constants and types for the step_scheduler stepper pulse scheduler.
package step_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] ADR_CTRL      = 4'd0;
  localparam logic [3:0] ADR_LAST_TIME = 4'd1;
  localparam logic [3:0] ADR_INTERVAL  = 4'd2;
  localparam logic [3:0] ADR_PUSH      = 4'd3;
  localparam logic [3:0] ADR_POSITION  = 4'd4;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_SHUTDOWN_BIT = 1;
  localparam int CTRL_OVERFLOW_BIT = 2;
  localparam int CTRL_COUNT_LSB    = 4;
  localparam int CTRL_COUNT_W      = 4;
  localparam int CTRL_STATE_LSB    = 8;

  localparam int PUSH_COUNT_LSB = 0;
  localparam int PUSH_COUNT_W   = 16;
  localparam int PUSH_ADD_LSB   = 16;
  localparam int PUSH_ADD_W     = 15;
  localparam int PUSH_DIR_BIT   = 31;

  localparam int ENTRY_W = 64;

  // Field order matches {INTERVAL staging, PUSH data word}.
  typedef struct packed {
    logic [31:0]           interval;
    logic                  dir;
    logic [PUSH_ADD_W-1:0] add;
    logic [PUSH_COUNT_W-1:0] count;
  } entry_t;

  function automatic logic [31:0] sext_add(input logic [PUSH_ADD_W-1:0] a);
    return {{(32 - PUSH_ADD_W){a[PUSH_ADD_W-1]}}, a};
  endfunction

endpackage

// File: rtl/step_scheduler_fifo.sv
// Move queue for step_scheduler: synchronous FIFO with flush; a push into a
// full queue succeeds when a pop happens in the same cycle.
module step_scheduler_fifo
  import step_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: non-blocking assignments in sequential blocks keep flop updates race-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; pointers and count alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/step_scheduler.sv
// Wishbone stepper pulse scheduler: queued moves become timed step/dir pulses.
// Define STEP_SCHEDULER_POSITION_EN to add the signed POSITION register (reg 4).
module step_scheduler
  import step_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int PULSE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] counter,
  input  logic        shutdown,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        step,
  output logic        dir,
  output logic        irq
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              shut_lat_q, shut_lat_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       last_time_q, last_time_d;
  logic [31:0]       interval_stage_q, interval_stage_d;
  logic [31:0]       cur_interval_q, cur_interval_d;
  logic [31:0]       next_time_q, next_time_d;
  logic [15:0]       cur_count_q, cur_count_d;
  logic [14:0]       cur_add_q, cur_add_d;
  logic [7:0]        pulse_cnt_q, pulse_cnt_d;
  logic              dir_q, dir_d, step_q, step_d;
  logic              ack_q, ack_d, irq_q, irq_d;
  logic [31:0]       dat_q, dat_d;
`ifdef STEP_SCHEDULER_POSITION_EN
  logic [31:0]       position_q, position_d;
`endif

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  entry_t            head;
  logic              wb_req, wb_wr, wb_rd, due, do_load;
  logic [15:0]       push_count, new_count;
  logic [31:0]       load_base, new_interval, ctrl_rd;

  assign wb_req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wb_wr      = wb_req & wb_we_i;
  assign wb_rd      = wb_req & ~wb_we_i;
  assign push_count = wb_dat_i[PUSH_COUNT_LSB +: PUSH_COUNT_W];
  assign fifo_push  = wb_wr && (wb_adr_i == ADR_PUSH) && (push_count != '0);
  // Wrap-safe: the target counts as reached once it lies at most 2^31 ticks behind.
  assign due        = $signed(counter - next_time_q) >= 0;

  step_scheduler_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({interval_stage_q, wb_dat_i}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d          = state_q;
    enable_d         = enable_q;
    shut_lat_d       = shut_lat_q;
    overflow_d       = overflow_q;
    last_time_d      = last_time_q;
    interval_stage_d = interval_stage_q;
    cur_interval_d   = cur_interval_q;
    next_time_d      = next_time_q;
    cur_count_d      = cur_count_q;
    cur_add_d        = cur_add_q;
    pulse_cnt_d      = pulse_cnt_q;
    dir_d            = dir_q;
    step_d           = step_q;
    fifo_pop         = 1'b0;
    fifo_flush       = 1'b0;
    do_load          = 1'b0;
    load_base        = last_time_q;
    new_count        = cur_count_q - 16'd1;
    new_interval     = cur_interval_q + sext_add(cur_add_q);
    ack_d            = wb_req;
    dat_d            = '0;

    ctrl_rd = '0;
    ctrl_rd[CTRL_ENABLE_BIT]   = enable_q;
    ctrl_rd[CTRL_SHUTDOWN_BIT] = shut_lat_q;
    ctrl_rd[CTRL_OVERFLOW_BIT] = overflow_q;
    ctrl_rd[CTRL_COUNT_LSB +: CTRL_COUNT_W] = 4'(fifo_count);
    ctrl_rd[CTRL_STATE_LSB +: 2] = state_q;

    if (wb_rd) begin
      case (wb_adr_i)
        ADR_CTRL:      dat_d = ctrl_rd;
        ADR_LAST_TIME: dat_d = last_time_q;
        ADR_INTERVAL:  dat_d = interval_stage_q;
        ADR_PUSH:      dat_d = {16'd0, cur_count_q};
`ifdef STEP_SCHEDULER_POSITION_EN
        ADR_POSITION:  dat_d = position_q;
`endif
        default:       dat_d = '0;
      endcase
    end

    if (wb_wr) begin
      case (wb_adr_i)
        ADR_CTRL: begin
          enable_d = wb_dat_i[CTRL_ENABLE_BIT];
          if (wb_dat_i[CTRL_SHUTDOWN_BIT]) shut_lat_d = 1'b0;
          if (wb_dat_i[CTRL_OVERFLOW_BIT]) overflow_d = 1'b0;
        end
        ADR_LAST_TIME: if (state_q == ST_IDLE) last_time_d = wb_dat_i;
        ADR_INTERVAL:  interval_stage_d = wb_dat_i;
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_q && !fifo_empty && !shut_lat_q) begin
          fifo_pop = 1'b1;
          do_load  = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable_q) begin
          fifo_flush  = 1'b1;
          cur_count_d = '0;
          state_d     = ST_IDLE;
        end else if (due) begin
          step_d      = 1'b1;
          pulse_cnt_d = 8'(PULSE_TICKS - 1);
          state_d     = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q != '0) begin
          pulse_cnt_d = pulse_cnt_q - 8'd1;
        end else begin
          step_d         = 1'b0;
          last_time_d    = next_time_q;
          cur_count_d    = new_count;
          cur_interval_d = new_interval;
          next_time_d    = next_time_q + new_interval;
          if (!enable_q) begin
            fifo_flush  = 1'b1;
            cur_count_d = '0;
            state_d     = ST_IDLE;
          end else if (new_count != '0) begin
            state_d = ST_WAIT;
          end else if (!fifo_empty) begin
            // Chain straight into the next move, timed from the step just taken.
            fifo_pop  = 1'b1;
            do_load   = 1'b1;
            load_base = next_time_q;
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (!shut_lat_q && !shutdown) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (shutdown) begin
      step_d      = 1'b0;
      pulse_cnt_d = '0;
      fifo_flush  = 1'b1;
      fifo_pop    = 1'b0;
      do_load     = 1'b0;
      cur_count_d = '0;
      shut_lat_d  = 1'b1;
      state_d     = ST_HALT;
    end

    if (do_load) begin
      cur_interval_d = head.interval;
      cur_count_d    = head.count;
      cur_add_d      = head.add;
      dir_d          = head.dir;
      next_time_d    = load_base + head.interval;
    end

    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;

`ifdef STEP_SCHEDULER_POSITION_EN
    position_d = position_q;
    if (step_d && !step_q) position_d = dir_q ? position_q - 32'd1 : position_q + 32'd1;
    if (wb_wr && (wb_adr_i == ADR_POSITION)) position_d = wb_dat_i;
`endif

    irq_d = (enable_q && (fifo_count < CW'(QUEUE_DEPTH))) || shut_lat_q || overflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      enable_q         <= 1'b0;
      shut_lat_q       <= 1'b0;
      overflow_q       <= 1'b0;
      last_time_q      <= '0;
      interval_stage_q <= '0;
      cur_interval_q   <= '0;
      next_time_q      <= '0;
      cur_count_q      <= '0;
      cur_add_q        <= '0;
      pulse_cnt_q      <= '0;
      dir_q            <= 1'b0;
      step_q           <= 1'b0;
      ack_q            <= 1'b0;
      irq_q            <= 1'b0;
      dat_q            <= '0;
`ifdef STEP_SCHEDULER_POSITION_EN
      position_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      enable_q         <= enable_d;
      shut_lat_q       <= shut_lat_d;
      overflow_q       <= overflow_d;
      last_time_q      <= last_time_d;
      interval_stage_q <= interval_stage_d;
      cur_interval_q   <= cur_interval_d;
      next_time_q      <= next_time_d;
      cur_count_q      <= cur_count_d;
      cur_add_q        <= cur_add_d;
      pulse_cnt_q      <= pulse_cnt_d;
      dir_q            <= dir_d;
      step_q           <= step_d;
      ack_q            <= ack_d;
      irq_q            <= irq_d;
      dat_q            <= dat_d;
`ifdef STEP_SCHEDULER_POSITION_EN
      position_q       <= position_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign irq      = irq_q;

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Wishbone-slave stepper pulse scheduler on the SPI-to-wishbone command bus, behind the bus dispatcher, next to the clock counter.
- Holds a small queue of moves. Each move is a first interval, a step count and a signed interval delta.
- Compares the free-running 32-bit clock counter against the scheduled step time and emits step/dir pulses.
- Drives the refill/error interrupt line and honours the external shutdown input.

Parameters:
- QUEUE_DEPTH, 4: move entries held (power of two, 2..16).
- PULSE_TICKS, 4: clk cycles the step output stays high (1..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- counter  input  32  free-running clock counter value
- shutdown  input  1  external emergency stop, active high
- wb_stb_i  input  1  wishbone strobe
- wb_cyc_i  input  1  wishbone cycle
- wb_we_i  input  1  wishbone write enable
- wb_adr_i  input  4  register address
- wb_dat_i  input  32  write data
- wb_dat_o  output  32  read data
- wb_ack_o  output  1  wishbone acknowledge
- step  output  1  step pulse
- dir  output  1  direction
- irq  output  1  level interrupt

Behaviour:
- Reset: all outputs 0, queue empty, state IDLE, all registers 0.
- Wishbone:
  - wb_ack_o pulses for exactly 1 cycle, registered, one cycle after stb&cyc is sampled high with ack low.
  - wb_dat_o is valid with ack and is 0 otherwise.
  - Unmapped addresses ack, read 0, ignore writes.
- Reg 0 CTRL:
  - bit0 enable: rw.
  - bit1 shutdown_latched: read; write 1 clears.
  - bit2 overflow: read; write 1 clears.
  - bits[7:4] queue count: read only.
  - bits[9:8] state: read only; IDLE=0, WAIT=1, PULSE=2, HALT=3.
- Reg 1 LAST_TIME: rw. Writes are accepted only in IDLE and are ignored otherwise.
- Reg 2 INTERVAL: staging register, rw.
- Reg 3 PUSH (write):
  - Data fields: [15:0] count, [30:16] add (signed 15-bit), [31] dir.
  - Enqueues {INTERVAL staging, data}.
  - count=0: dropped silently.
  - Queue full: dropped and overflow set.
  - Read returns remaining steps of the current move.
- State machine:
  - IDLE:
    - Condition to leave: enable & queue not empty & not shutdown_latched.
    - Action: pop an entry; load interval, count, add; dir updates this cycle; next_time = LAST_TIME + interval (32-bit wrap); go to WAIT.
  - WAIT:
    - Due test: due = signed(counter - next_time) >= 0. This is wrap-safe provided the target is within 2^31 ticks.
    - When due in cycle N: step rises at edge N+1; go to PULSE.
  - PULSE:
    - step stays high for exactly PULSE_TICKS cycles.
    - On the falling edge: LAST_TIME = next_time; count -= 1; interval += sign-extended add (32-bit wrap); next_time = next_time + new interval.
    - If count remains: go to WAIT.
    - Else if queue not empty and enable: pop the next entry and go to WAIT (same load as IDLE, using the updated LAST_TIME).
    - Else: go to IDLE.
    - Step low lasts at least 1 cycle, even if the next time is already past.
- Enable cleared mid-move: any active pulse completes at full width; then the current move and queue are flushed and the state goes to IDLE.
- Shutdown high (any state, sampled each cycle):
  - step forced 0 next cycle (pulse truncated); queue and move flushed; shutdown_latched set; go to HALT.
  - HALT exits to IDLE only once shutdown_latched has been cleared and the shutdown input is low.
- Simultaneous push and pop in the same cycle: both succeed; count unchanged. A full queue with a pop in the same cycle accepts the push.
- irq = (enable & queue count < QUEUE_DEPTH) | shutdown_latched | overflow. It is registered: 1-cycle latency.
- Reset mid-operation: everything clears asynchronously; step drops immediately.

Optional Feature:
- Macro: STEP_SCHEDULER_POSITION_EN.
- Defined:
  - Reg 4 POSITION: 32-bit signed, rw.
  - Changes by +1 (dir=0) or -1 (dir=1) on each step rising edge, wrapping.
  - A write in the same cycle as a step takes the written value.
- Undefined: reg 4 reads 0 and ignores writes; no position logic synthesised.

Decomposition:
- Package step_scheduler_pkg:
  - state encoding constants IDLE/WAIT/PULSE/HALT.
  - register address constants 0..4.
  - CTRL bit positions and PUSH field positions/widths.
  - entry width constant (64).
- Sub-module step_scheduler_fifo: synchronous FIFO, 64-bit entries, QUEUE_DEPTH deep.
  - Ports: push, pop, full, empty, count.
  - Same clock and async active-low reset.

Test Plan:
- Single move: LAST_TIME=100, INTERVAL=50, PUSH count=3 add=0 dir=1, enable, counter ramping from 0 -> dir=1 before the first step; step rises the cycle after counter=150, 200, 250; each pulse 4 cycles high; state IDLE after; reg3 reads 0.
- Acceleration: INTERVAL=100, add=-10, count=4, LAST_TIME=0 -> steps at 100, 190, 270, 340; LAST_TIME reads 340.
- Wrap: LAST_TIME=0xFFFFFFF0, INTERVAL=0x20 -> step at counter=0x00000010, not immediately.
- Overflow: push 5 entries with QUEUE_DEPTH=4, enable=0 -> count=4, overflow=1, irq=1; write CTRL with bit2 set -> overflow=0.
- Shutdown mid-pulse: assert shutdown in the 2nd high cycle -> step low next cycle, queue count 0, state HALT; clear latch with shutdown low -> IDLE.
- Position (macro on): 3 steps dir=0 then 2 steps dir=1 from POSITION=10 -> reads 11.
